rv_gpr_banked_stage: RTL and testbench

Next-generation GPR stage: per-warp, per-thread register file split into NUM_BANKS single-read/single-write banks.
- An operand-collector FSM accepts a request of up to NUM_SRC source registers and resolves bank conflicts by issuing reads over multiple cycles.
- It returns all operands together on a valid/ready response.
- Sits between issue/scoreboard and dispatch; the writeback port is always ready.

---
 rtl/rv_gpr_banked_stage.sv | 198 +++++++++++++++++++
 tb/tb_rv_gpr_banked_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rv_gpr_banked_stage.sv
// Banked per-warp GPR file with an operand-collector FSM; bank conflicts are resolved over extra COLLECT cycles.
// Optional GPR_CONFLICT_STATS_EN adds saturating request/conflict-cycle counters.
module rv_gpr_banked_stage #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 32,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_SRC     = 3,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NR_BITS     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
`ifdef GPR_CONFLICT_STATS_EN
  output logic [31:0]                       o_stat_req_cnt,
  output logic [31:0]                       o_stat_conflict_cnt,
`endif
  input  logic                              i_wb_valid,
  output logic                              o_wb_ready,
  input  logic [NW_BITS-1:0]                i_wb_wid,
  input  logic [NR_BITS-1:0]                i_wb_rd,
  input  logic [NUM_THREADS-1:0]            i_wb_tmask,
  input  logic [NUM_THREADS*32-1:0]         i_wb_data,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic [NW_BITS-1:0]                i_req_wid,
  input  logic [NUM_SRC*NR_BITS-1:0]        i_req_rs,
  input  logic [NUM_SRC-1:0]                i_req_smask,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [NW_BITS-1:0]                o_rsp_wid,
  output logic [NUM_SRC*NUM_THREADS*32-1:0] o_rsp_data
);

  localparam int DW    = NUM_THREADS * 32;
  localparam int BB    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RPB   = NUM_REGS / NUM_BANKS;
  localparam int NROWS = NUM_WARPS * RPB;
  localparam int RW    = (NROWS > 1) ? $clog2(NROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RSP} state_t;

  function automatic logic [BB-1:0] f_bank(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] r);
    int s;
    s = (int'(r) + int'(wid)) % NUM_BANKS;
    return BB'(s);
  endfunction

  function automatic logic [RW-1:0] f_row(input logic [NW_BITS-1:0] wid, input logic [NR_BITS-1:0] r);
    int s;
    s = int'(wid) * RPB + int'(r) / NUM_BANKS;
    return RW'(s);
  endfunction

  logic [DW-1:0]              r_mem [NUM_BANKS][NROWS];
  state_t                     r_state;
  logic [NW_BITS-1:0]         r_wid;
  logic [NUM_SRC*NR_BITS-1:0] r_rs;
  logic [NUM_SRC-1:0]         r_pend;
  logic [DW-1:0]              r_opnd [NUM_SRC];
  logic                       r_rsp_valid;

  logic                       w_wb_en;
  logic [BB-1:0]              w_wb_bank;
  logic [RW-1:0]              w_wb_row;
  logic [BB-1:0]              w_src_bank [NUM_SRC];
  logic [RW-1:0]              w_src_row  [NUM_SRC];
  logic [DW-1:0]              w_src_data [NUM_SRC];
  logic [NUM_SRC-1:0]         w_grant;
  logic [NUM_SRC-1:0]         w_req_pend;
  logic [NUM_SRC-1:0]         w_pend_left;
  logic                       w_accept;

  assign o_wb_ready  = 1'b1;
  assign w_wb_en     = i_wb_valid && (i_wb_rd != '0);
  assign w_wb_bank   = f_bank(i_wb_wid, i_wb_rd);
  assign w_wb_row    = f_row(i_wb_wid, i_wb_rd);
  assign o_req_ready = i_rst_n && ((r_state == S_IDLE) || ((r_state == S_RSP) && i_rsp_ready));
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_wid   = r_wid;
  assign w_pend_left = r_pend & ~w_grant;

  // Storage is deliberately outside reset: register contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (w_wb_en) begin
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (i_wb_tmask[l]) r_mem[w_wb_bank][w_wb_row][l*32 +: 32] <= i_wb_data[l*32 +: 32];
      end
    end
  end

  // Bank read with same-cycle writeback forwarding on the enabled lanes only.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      w_src_bank[k] = f_bank(r_wid, r_rs[k*NR_BITS +: NR_BITS]);
      w_src_row[k]  = f_row(r_wid, r_rs[k*NR_BITS +: NR_BITS]);
      w_src_data[k] = r_mem[w_src_bank[k]][w_src_row[k]];
      if (w_wb_en && (w_wb_bank == w_src_bank[k]) && (w_wb_row == w_src_row[k])) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
          if (i_wb_tmask[l]) w_src_data[k][l*32 +: 32] = i_wb_data[l*32 +: 32];
        end
      end
    end
  end

  // Each bank serves the lowest-index pending source mapped to it.
  always_comb begin
    w_grant = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_grant[k] = r_pend[k] && (r_state == S_COLLECT);
      for (int j = 0; j < k; j++) begin
        if (r_pend[j] && (w_src_bank[j] == w_src_bank[k])) w_grant[k] = 1'b0;
      end
    end
  end

  always_comb begin
    w_req_pend = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_req_pend[k] = i_req_smask[k] && (i_req_rs[k*NR_BITS +: NR_BITS] != '0);
    end
  end

  always_comb begin
    o_rsp_data = '0;
    for (int k = 0; k < NUM_SRC; k++) o_rsp_data[k*DW +: DW] = r_opnd[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_wid       <= '0;
      r_rs        <= '0;
      r_pend      <= '0;
      r_rsp_valid <= 1'b0;
      for (int k = 0; k < NUM_SRC; k++) r_opnd[k] <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          for (int k = 0; k < NUM_SRC; k++) begin
            if (w_grant[k]) r_opnd[k] <= w_src_data[k];
          end
          r_pend <= w_pend_left;
          if (w_pend_left == '0) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RSP: begin
          if (i_rsp_ready && !i_req_valid) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      // Accept overrides the state update above (IDLE, or RSP back-to-back).
      if (w_accept) begin
        r_wid  <= i_req_wid;
        r_rs   <= i_req_rs;
        r_pend <= w_req_pend;
        for (int k = 0; k < NUM_SRC; k++) r_opnd[k] <= '0;
        if (w_req_pend == '0) begin
          r_state     <= S_RSP;
          r_rsp_valid <= 1'b1;
        end else begin
          r_state     <= S_COLLECT;
          r_rsp_valid <= 1'b0;
        end
      end
    end
  end

`ifdef GPR_CONFLICT_STATS_EN
  logic        r_first;
  logic [31:0] r_req_cnt;
  logic [31:0] r_conf_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first    <= 1'b0;
      r_req_cnt  <= '0;
      r_conf_cnt <= '0;
    end else begin
      if (w_accept) r_first <= 1'b1;
      else if (r_state == S_COLLECT) r_first <= 1'b0;
      if (w_accept && (r_req_cnt != 32'hFFFF_FFFF)) r_req_cnt <= r_req_cnt + 32'd1;
      if ((r_state == S_COLLECT) && !r_first && (r_conf_cnt != 32'hFFFF_FFFF))
        r_conf_cnt <= r_conf_cnt + 32'd1;
    end
  end

  assign o_stat_req_cnt      = r_req_cnt;
  assign o_stat_conflict_cnt = r_conf_cnt;
`endif

endmodule

// File: tb/tb_rv_gpr_banked_stage.sv
// Directed bench for rv_gpr_banked_stage (default build, stats disabled).
module tb_rv_gpr_banked_stage;
  localparam int NT = 4;
  localparam int NS = 3;
  localparam int DW = NT * 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_valid = 1'b0;
  logic              wb_ready;
  logic [1:0]        wb_wid = '0;
  logic [4:0]        wb_rd = '0;
  logic [NT-1:0]     wb_tmask = '0;
  logic [DW-1:0]     wb_data = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_wid = '0;
  logic [NS*5-1:0]   req_rs = '0;
  logic [NS-1:0]     req_smask = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_wid;
  logic [NS*DW-1:0]  rsp_data;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [NS*DW-1:0] held;

  always #5 clk = ~clk;

  rv_gpr_banked_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_wid(wb_wid), .i_wb_rd(wb_rd),
    .i_wb_tmask(wb_tmask), .i_wb_data(wb_data),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wid(req_wid),
    .i_req_rs(req_rs), .i_req_smask(req_smask),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wid(rsp_wid), .o_rsp_data(rsp_data)
  );

  function automatic logic [DW-1:0] lanes(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic chk(input string tag, input logic [NS*DW-1:0] obs, input logic [NS*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [1:0] wid, input logic [4:0] rd, input logic [3:0] m, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_wid = wid; wb_rd = rd; wb_tmask = m; wb_data = d;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] wid, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [2:0] sm);
    req_valid = 1'b1; req_wid = wid; req_rs = {r2, r1, r0}; req_smask = sm;
  endtask

  // Cycles counted from the accept edge (1 = visible right after that edge).
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic req(input logic [1:0] wid, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [2:0] sm, output int n);
    drive_req(wid, r0, r1, r2, sm);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(n);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {383'd0, rsp_valid}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_rsp_valid", {383'd0, rsp_valid}, '0);
    chk("rst_req_ready", {383'd0, req_ready}, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("wb_ready", {383'd0, wb_ready}, 384'd1);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("rel_req_ready", {383'd0, req_ready}, 384'd1);

    // 1: single source plus r0 sources
    wb(2'd0, 5'd5, 4'hF, lanes(32'hA5A5_0000));
    req(2'd0, 5'd5, 5'd0, 5'd0, 3'b111, lat);
    chk("t1_lat", 384'(lat), 384'd2);
    chk("t1_data", rsp_data, {256'd0, lanes(32'hA5A5_0000)});
    chk("t1_req_ready_hold", {383'd0, req_ready}, '0);
    consume();

    // 2: three sources all on bank 3 for warp 1
    wb(2'd1, 5'd2,  4'hF, lanes(32'h1000_0200));
    wb(2'd1, 5'd6,  4'hF, lanes(32'h1000_0600));
    wb(2'd1, 5'd10, 4'hF, lanes(32'h1000_0A00));
    req(2'd1, 5'd2, 5'd6, 5'd10, 3'b111, lat);
    chk("t2_lat", 384'(lat), 384'd4);
    chk("t2_data", rsp_data, {lanes(32'h1000_0A00), lanes(32'h1000_0600), lanes(32'h1000_0200)});
    chk("t2_wid", 384'(rsp_wid), 384'd1);
    consume();

    // 3: writeback to r7 lanes 0,2 in the read cycle
    wb(2'd0, 5'd7, 4'hF, lanes(32'h0700_0000));
    drive_req(2'd0, 5'd7, 5'd0, 5'd0, 3'b001);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 5'd7; wb_tmask = 4'b0101; wb_data = lanes(32'hBEEF_0000);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("t3_valid", {383'd0, rsp_valid}, 384'd1);
    chk("t3_fwd", rsp_data, {256'd0, 32'h0700_0003, 32'hBEEF_0002, 32'h0700_0001, 32'hBEEF_0000});
    consume();

    // 4: stall with a writeback to a captured source, then back-to-back accept
    req(2'd0, 5'd5, 5'd7, 5'd0, 3'b011, lat);
    chk("t4_lat", 384'(lat), 384'd2);
    held = {128'd0, 32'h0700_0003, 32'hBEEF_0002, 32'h0700_0001, 32'hBEEF_0000, lanes(32'hA5A5_0000)};
    chk("t4_data", rsp_data, held);
    wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 5'd5; wb_tmask = 4'hF; wb_data = lanes(32'hDEAD_0000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      wb_valid = 1'b0;
      chk("t4_hold_valid", {383'd0, rsp_valid}, 384'd1);
      chk("t4_hold_data", rsp_data, held);
    end
    drive_req(2'd0, 5'd5, 5'd0, 5'd0, 3'b001);
    rsp_ready = 1'b1; #1;
    chk("t4_b2b_ready", {383'd0, req_ready}, 384'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("t4_b2b_collect", {383'd0, rsp_valid}, '0);
    wait_rsp(lat);
    chk("t4_b2b_lat", 384'(lat), 384'd2);
    chk("t4_b2b_data", rsp_data, {256'd0, lanes(32'hDEAD_0000)});
    consume();

    // 5: reset during COLLECT of the conflicting request
    drive_req(2'd1, 5'd2, 5'd6, 5'd10, 3'b111);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_pre_rst_valid", {383'd0, rsp_valid}, '0);
    rst_n = 1'b0; #1;
    chk("t5_rst_valid", {383'd0, rsp_valid}, '0);
    chk("t5_rst_data", rsp_data, '0);
    chk("t5_rst_wid", 384'(rsp_wid), '0);
    chk("t5_rst_ready", {383'd0, req_ready}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("t5_rel_ready", {383'd0, req_ready}, 384'd1);
    req(2'd1, 5'd2, 5'd6, 5'd10, 3'b111, lat);
    chk("t5_lat", 384'(lat), 384'd4);
    chk("t5_data", rsp_data, {lanes(32'h1000_0A00), lanes(32'h1000_0600), lanes(32'h1000_0200)});
    consume();

    // 6: no sources used
    req(2'd0, 5'd5, 5'd7, 5'd2, 3'b000, lat);
    chk("t6_lat", 384'(lat), 384'd1);
    chk("t6_data", rsp_data, '0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
